// File: rtl/multicycle_control_pkg.sv
// Shared opcode and state encodings for the 8-bit core's control path.
// Also used by the single-cycle Control decoder and the testbench.
package cpu_ctrl_pkg;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_LD  = 2'b01;
    localparam logic [1:0] OP_ST  = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory.
interface multicycle_control_if;
    logic [1:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] state;
    logic       mem_err;

    modport master (
        output op, zero, mem_ready,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               alu_op, alu_src, reg_dst, mem_to_reg, reg_write, state, mem_err
    );

    modport slave (
        input  op, zero, mem_ready,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               alu_op, alu_src, reg_dst, mem_to_reg, reg_write, state, mem_err
    );
endinterface

// File: rtl/multicycle_control_timer.sv
// Memory wait counter: counts stalled cycles and flags when the timeout is reached.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] wait_cnt;

    // Saturates rather than wrapping so a disabled timeout cannot alias back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count_en && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory
// ready handshake and a sticky HALT on memory timeout.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);
    state_t     state_q;
    logic [1:0] op_q;
    logic       mem_err_q;
    logic       wait_en;
    logic       expired;

    logic pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
    logic alu_op, alu_src, reg_dst, mem_to_reg, reg_write;

    // Counter is held clear outside stalled FETCH/MEM cycles, so it starts at zero on entry.
    assign wait_en = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!wait_en),
        .count_en (wait_en),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= OP_ALU;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state_q <= S_DECODE;
                    end else if (expired) begin
                        state_q   <= S_HALT;
                        mem_err_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q    <= bus.op;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ALU:       state_q <= S_WB;
                        OP_LD, OP_ST: state_q <= S_MEM;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        state_q <= (op_q == OP_LD) ? S_WB : S_FETCH;
                    end else if (expired) begin
                        state_q   <= S_HALT;
                        mem_err_q <= 1'b1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Decoded outputs are gated by reset so nothing is asserted during an async reset.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ALU: begin
                            alu_op  = 1'b1;
                            reg_dst = 1'b1;
                        end
                        OP_LD, OP_ST: alu_src = 1'b1;
                        default: begin
                            pc_src   = 1'b1;
                            pc_write = bus.zero;
                        end
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (op_q == OP_LD);
                    mem_write = (op_q == OP_ST);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LD);
                    reg_dst    = (op_q == OP_ALU);
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.ir_write   = ir_write;
    assign bus.i_or_d     = i_or_d;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.alu_op     = alu_op;
    assign bus.alu_src    = alu_src;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.state      = state_q;
    assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: default-timeout instance plus a MEM_TIMEOUT=4 instance.
module tb_multicycle_control;
    import cpu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multicycle_control_if bus ();
    multicycle_control_if bus4 ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multicycle_control #(.MEM_TIMEOUT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, alu_op, alu_src, reg_dst, mem_to_reg, reg_write}
    logic [10:0] ctl;
    logic [10:0] ctl4;
    assign ctl  = {bus.pc_write, bus.pc_src, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                   bus.alu_op, bus.alu_src, bus.reg_dst, bus.mem_to_reg, bus.reg_write};
    assign ctl4 = {bus4.pc_write, bus4.pc_src, bus4.ir_write, bus4.i_or_d, bus4.mem_read, bus4.mem_write,
                   bus4.alu_op, bus4.alu_src, bus4.reg_dst, bus4.mem_to_reg, bus4.reg_write};

    localparam logic [10:0] C_NONE    = 11'b000_0000_0000;
    localparam logic [10:0] C_FETCH_R = 11'b101_0100_0000;
    localparam logic [10:0] C_FETCH_W = 11'b000_0100_0000;
    localparam logic [10:0] C_EX_ALU  = 11'b000_0001_0100;
    localparam logic [10:0] C_EX_ADDR = 11'b000_0000_1000;
    localparam logic [10:0] C_MEM_LD  = 11'b000_1100_0000;
    localparam logic [10:0] C_MEM_ST  = 11'b000_1010_0000;
    localparam logic [10:0] C_WB_ALU  = 11'b000_0000_0101;
    localparam logic [10:0] C_WB_LD   = 11'b000_0000_0011;
    localparam logic [10:0] C_BR_T    = 11'b110_0000_0000;
    localparam logic [10:0] C_BR_N    = 11'b010_0000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.op = OP_ALU;  bus.zero = 1'b0;  bus.mem_ready = 1'b1;
        bus4.op = OP_ALU; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", bus.state);
        end
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE);
        end
        checks++;
        if (bus.mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_mem_err got %b want 0", bus.mem_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [2:0]  es [0:3];
        logic [10:0] ec [0:3];
        es = '{3'd0, 3'd1, 3'd2, 3'd4};
        ec = '{C_FETCH_R, C_NONE, C_EX_ALU, C_WB_ALU};
        bus.op = OP_ALU; bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.state !== es[i]) begin
                errors++; $display("FAIL alu_state[%0d] got %0d want %0d", i, bus.state, es[i]);
            end
            checks++;
            if (ctl !== ec[i]) begin
                errors++; $display("FAIL alu_ctl[%0d] got %b want %b", i, ctl, ec[i]);
            end
            cyc();
        end
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL alu_end_state got %0d want 0", bus.state);
        end
    endtask

    task automatic test_load();
        logic [2:0]  es [0:4];
        logic [10:0] ec [0:4];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        ec = '{C_FETCH_R, C_NONE, C_EX_ADDR, C_MEM_LD, C_WB_LD};
        bus.op = OP_LD; bus.mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.state !== es[i]) begin
                errors++; $display("FAIL load_state[%0d] got %0d want %0d", i, bus.state, es[i]);
            end
            checks++;
            if (ctl !== ec[i]) begin
                errors++; $display("FAIL load_ctl[%0d] got %b want %b", i, ctl, ec[i]);
            end
            cyc();
        end
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL load_end_state got %0d want 0", bus.state);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  es [0:2];
        logic [10:0] ec [0:2];
        es = '{3'd0, 3'd1, 3'd2};
        bus.op = OP_BR; bus.mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            ec = '{C_FETCH_R, C_NONE, (z == 1) ? C_BR_T : C_BR_N};
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (bus.state !== es[i]) begin
                    errors++; $display("FAIL br%0d_state[%0d] got %0d want %0d", z, i, bus.state, es[i]);
                end
                checks++;
                if (ctl !== ec[i]) begin
                    errors++; $display("FAIL br%0d_ctl[%0d] got %b want %b", z, i, ctl, ec[i]);
                end
                cyc();
            end
            checks++;
            if (bus.state !== 3'd0) begin
                errors++; $display("FAIL br%0d_end_state got %0d want 0", z, bus.state);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_store_wait();
        logic [2:0]  es [0:6];
        logic [10:0] ec [0:6];
        logic [1:0]  eo [0:6];
        logic        er [0:6];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
        ec = '{C_FETCH_R, C_NONE, C_EX_ADDR, C_MEM_ST, C_MEM_ST, C_MEM_ST, C_MEM_ST};
        eo = '{OP_ST, OP_ST, OP_BR, OP_BR, OP_ALU, OP_ALU, OP_ALU};
        er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            bus.op = eo[i];
            bus.mem_ready = er[i];
            #1;
            checks++;
            if (bus.state !== es[i]) begin
                errors++; $display("FAIL store_state[%0d] got %0d want %0d", i, bus.state, es[i]);
            end
            checks++;
            if (ctl !== ec[i]) begin
                errors++; $display("FAIL store_ctl[%0d] got %b want %b", i, ctl, ec[i]);
            end
            cyc();
        end
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL store_end_state got %0d want 0", bus.state);
        end
        checks++;
        if (bus.mem_err !== 1'b0) begin
            errors++; $display("FAIL store_mem_err got %b want 0", bus.mem_err);
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        bus.op = OP_ST; bus.mem_ready = 1'b1;
        cyc();
        cyc();
        bus.op = OP_ALU; bus.mem_ready = 1'b0;
        cyc();
        #1;
        checks++;
        if (bus.state !== 3'd3 || bus.mem_write !== 1'b1) begin
            errors++; $display("FAIL rmid_in_mem got state %0d mem_write %b want 3 1", bus.state, bus.mem_write);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            errors++; $display("FAIL rmid_ctl got %b want %b", ctl, C_NONE);
        end
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL rmid_state got %0d want 0", bus.state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus4.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus4.state !== 3'd0 || ctl4 !== C_FETCH_W) begin
                errors++; $display("FAIL to4_wait[%0d] got state %0d ctl %b want 0 %b", k, bus4.state, ctl4, C_FETCH_W);
            end
            cyc();
        end
        #1;
        checks++;
        if (bus4.state !== 3'd7) begin
            errors++; $display("FAIL to4_halt_state got %0d want 7", bus4.state);
        end
        checks++;
        if (bus4.mem_err !== 1'b1 || ctl4 !== C_NONE) begin
            errors++; $display("FAIL to4_halt_out got mem_err %b ctl %b want 1 %b", bus4.mem_err, ctl4, C_NONE);
        end
        checks++;
        if (bus.state !== 3'd0 || bus.mem_err !== 1'b0) begin
            errors++; $display("FAIL to15_early got state %0d mem_err %b want 0 0", bus.state, bus.mem_err);
        end
        repeat (10) cyc();
        #1;
        checks++;
        if (bus.state !== 3'd0) begin
            errors++; $display("FAIL to15_cycle16 got state %0d want 0", bus.state);
        end
        cyc();
        #1;
        checks++;
        if (bus.state !== 3'd7 || bus.mem_err !== 1'b1) begin
            errors++; $display("FAIL to15_halt got state %0d mem_err %b want 7 1", bus.state, bus.mem_err);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus4.state !== 3'd0 || bus4.mem_err !== 1'b0 || ctl4 !== C_NONE) begin
            errors++; $display("FAIL to4_reset got state %0d mem_err %b ctl %b want 0 0 0", bus4.state, bus4.mem_err, ctl4);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_store_wait();
        test_reset_mid_mem();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
